uart_command_rx: RTL and testbench

UART_COMMAND_RX -- requirements
Module: uart_command_rx

---
 rtl/uart_command_rx.sv | 153 +++++++++++++++
 tb/tb_uart_command_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_command_rx.sv
// uart_command_rx: 8N1 UART receiver with a registered command/difficulty
// decoder. Framed bytes appear on data_rx with a data_valid pulse; the
// decoder answers one cycle later with cmd_valid or unknown_char.
module uart_command_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_rx,
  output logic       data_valid,
  output logic       framing_error,
  output logic [2:0] command,
  output logic [2:0] difficulty,
  output logic       cmd_valid,
  output logic       unknown_char
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r;
  logic [CW-1:0] baud_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          sync1_r;
  logic          sync2_r;
  logic          rx_s;

  assign rx_s = sync2_r;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= serial_in;
      sync2_r <= sync1_r;
    end
  end

  // Receive FSM: start-bit qualification at mid-bit, then one sample per bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      baud_cnt_r    <= '0;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'h00;
      data_rx       <= 8'h00;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      case (state_r)
        IDLE: begin
          baud_cnt_r <= '0;
          bit_cnt_r  <= 3'd0;
          if (!rx_s) begin
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (baud_cnt_r == HALF_CNT) begin
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            // A line that is high again at mid-bit was only a glitch
            if (!rx_s) begin
              state_r <= DATA;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt_r == LAST_CNT) begin
            baud_cnt_r         <= '0;
            shift_r[bit_cnt_r] <= rx_s;
            if (bit_cnt_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt_r == LAST_CNT) begin
            baud_cnt_r <= '0;
            state_r    <= IDLE;
            if (rx_s) begin
              data_rx    <= shift_r;
              data_valid <= 1'b1;
            end else begin
              framing_error <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= '0;
          bit_cnt_r  <= 3'd0;
        end
      endcase
    end
  end

  // Decoder: acts on the byte latched by the previous cycle's data_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      command      <= 3'd0;
      difficulty   <= 3'd1;
      cmd_valid    <= 1'b0;
      unknown_char <= 1'b0;
    end else begin
      cmd_valid    <= 1'b0;
      unknown_char <= 1'b0;
      if (data_valid) begin
        case (data_rx)
          8'h53: begin command <= 3'd0; cmd_valid <= 1'b1; end
          8'h46: begin command <= 3'd1; cmd_valid <= 1'b1; end
          8'h4C: begin command <= 3'd2; cmd_valid <= 1'b1; end
          8'h52: begin command <= 3'd3; cmd_valid <= 1'b1; end
          8'h42: begin command <= 3'd4; cmd_valid <= 1'b1; end
          8'h31: begin difficulty <= 3'd1; cmd_valid <= 1'b1; end
          8'h32: begin difficulty <= 3'd2; cmd_valid <= 1'b1; end
          8'h33: begin difficulty <= 3'd3; cmd_valid <= 1'b1; end
          default: unknown_char <= 1'b1;
        endcase
      end else begin
        cmd_valid    <= 1'b0;
        unknown_char <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_command_rx.sv
// Bench for uart_command_rx: directed scenarios plus random frames, checked
// against a frame-level model (expected byte/stop queue and decode tables).
module tb_uart_command_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_rx;
  logic       data_valid;
  logic       framing_error;
  logic [2:0] command;
  logic [2:0] difficulty;
  logic       cmd_valid;
  logic       unknown_char;

  uart_command_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in),
    .data_rx(data_rx), .data_valid(data_valid), .framing_error(framing_error),
    .command(command), .difficulty(difficulty),
    .cmd_valid(cmd_valid), .unknown_char(unknown_char)
  );

  always #5 clk = ~clk;

  // Expected frames (written by stimulus), consumed by the monitor via rd_idx
  logic [7:0] exp_byte[$];
  logic       exp_stop[$];
  int         rd_idx = 0;

  // Literal expectations posted by stimulus, evaluated by the monitor
  string lit_n[$];
  int    lit_a[$];
  int    lit_e[$];
  int    lit_rd = 0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int n_dv = 0, n_fe = 0, n_cv = 0, n_uc = 0;
  int b_dv, b_fe, b_cv, b_uc;

  string cmd_chars  = "SFLRB";
  string diff_chars = "123";
  string all_chars  = "SFLRB123";

  function automatic int cmd_idx(input logic [7:0] b);
    for (int i = 0; i < cmd_chars.len(); i++)
      if (cmd_chars[i] == b) return i;
    return -1;
  endfunction

  function automatic int diff_level(input logic [7:0] b);
    for (int i = 0; i < diff_chars.len(); i++)
      if (diff_chars[i] == b) return i + 1;
    return -1;
  endfunction

  task automatic ck(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic lit(input string name, input int act, input int exp);
    lit_n.push_back(name);
    lit_a.push_back(act);
    lit_e.push_back(exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    serial_in = v;
    idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    exp_byte.push_back(b);
    exp_stop.push_back(stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    serial_in = 1'b1;
  endtask

  task automatic snap();
    b_dv = n_dv; b_fe = n_fe; b_cv = n_cv; b_uc = n_uc;
  endtask

  // Monitor: compares DUT against the frame-level model every cycle
  initial begin
    int m_data, m_cmd, m_diff, ci, di;
    logic pend, exp_cv, exp_uc, p_dv, p_fe, p_cv, p_uc;
    logic [7:0] pend_b;
    m_data = 0; m_cmd = 0; m_diff = 1; pend = 1'b0; pend_b = 8'h00;
    p_dv = 1'b0; p_fe = 1'b0; p_cv = 1'b0; p_uc = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ck("reset_pulses", {data_valid, framing_error, cmd_valid, unknown_char}, 0);
        ck("reset_data_rx", data_rx, 0);
        ck("reset_command", command, 0);
        ck("reset_difficulty", difficulty, 1);
        m_data = 0; m_cmd = 0; m_diff = 1; pend = 1'b0;
        p_dv = 1'b0; p_fe = 1'b0; p_cv = 1'b0; p_uc = 1'b0;
      end else begin
        exp_cv = 1'b0;
        exp_uc = 1'b0;
        if (pend) begin
          ci = cmd_idx(pend_b);
          di = diff_level(pend_b);
          if (ci >= 0) begin
            m_cmd = ci; exp_cv = 1'b1;
          end else if (di >= 0) begin
            m_diff = di; exp_cv = 1'b1;
          end else begin
            exp_uc = 1'b1;
          end
        end
        ck("cmd_valid", cmd_valid, exp_cv);
        ck("unknown_char", unknown_char, exp_uc);
        ck("command", command, m_cmd);
        ck("difficulty", difficulty, m_diff);
        pend = 1'b0;
        ck("dv_fe_exclusive", data_valid & framing_error, 0);
        ck("pulse_single_cycle",
           (p_dv & data_valid) | (p_fe & framing_error) | (p_cv & cmd_valid) | (p_uc & unknown_char), 0);
        if (data_valid || framing_error) begin
          ck("frame_outstanding", rd_idx < exp_byte.size(), 1);
          if (rd_idx < exp_byte.size()) begin
            ck("stop_outcome", data_valid, exp_stop[rd_idx]);
            if (data_valid) begin
              m_data = exp_byte[rd_idx];
              pend   = 1'b1;
              pend_b = exp_byte[rd_idx];
            end
            rd_idx++;
          end
        end
        ck("data_rx", data_rx, m_data);
        n_dv += data_valid; n_fe += framing_error; n_cv += cmd_valid; n_uc += unknown_char;
        p_dv = data_valid; p_fe = framing_error; p_cv = cmd_valid; p_uc = unknown_char;
      end
      while (lit_rd < lit_n.size()) begin
        ck(lit_n[lit_rd], lit_a[lit_rd], lit_e[lit_rd]);
        lit_rd++;
      end
    end
  end

  // Stimulus: directed scenarios, then randomized frames
  initial begin
    logic [7:0] b;
    logic       ok;
    reset = 1'b0;
    serial_in = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(10);

    // 'F' decodes to command 1, difficulty stays at its reset value
    snap();
    send_frame(8'h46, 1'b1);
    idle(5);
    lit("F_data_rx", data_rx, 8'h46);
    lit("F_command", command, 1);
    lit("F_difficulty", difficulty, 1);
    lit("F_dv_count", n_dv - b_dv, 1);
    lit("F_cv_count", n_cv - b_cv, 1);

    // '3' then 'L' with no idle gap
    snap();
    send_frame(8'h33, 1'b1);
    send_frame(8'h4C, 1'b1);
    idle(5);
    lit("b2b_difficulty", difficulty, 3);
    lit("b2b_command", command, 2);
    lit("b2b_cv_count", n_cv - b_cv, 2);
    lit("b2b_fe_count", n_fe - b_fe, 0);

    // 'S' with a low stop bit is not decoded
    snap();
    send_frame(8'h53, 1'b0);
    idle(12);
    lit("fe_count", n_fe - b_fe, 1);
    lit("fe_dv_count", n_dv - b_dv, 0);
    lit("fe_command", command, 2);

    // Short low glitch is rejected, then 'R' decodes
    snap();
    serial_in = 1'b0;
    idle(3);
    serial_in = 1'b1;
    idle(12);
    lit("glitch_pulses", (n_dv - b_dv) + (n_fe - b_fe) + (n_cv - b_cv) + (n_uc - b_uc), 0);
    send_frame(8'h52, 1'b1);
    idle(5);
    lit("R_command", command, 3);

    // 'Z' is outside the decode table
    snap();
    send_frame(8'h5A, 1'b1);
    idle(5);
    lit("Z_uc_count", n_uc - b_uc, 1);
    lit("Z_cv_count", n_cv - b_cv, 0);
    lit("Z_data_rx", data_rx, 8'h5A);
    lit("Z_command", command, 3);
    lit("Z_difficulty", difficulty, 3);

    // Reset during bit 4 of 'B' discards the partial frame
    snap();
    b = 8'h42;
    serial_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      serial_in = b[i];
      idle(CPB);
    end
    serial_in = b[4];
    idle(3);
    reset = 1'b0;
    serial_in = 1'b1;
    idle(5);
    reset = 1'b1;
    idle(10);
    lit("rst_data_rx", data_rx, 0);
    lit("rst_command", command, 0);
    lit("rst_difficulty", difficulty, 1);
    lit("rst_dv_count", n_dv - b_dv, 0);
    snap();
    send_frame(8'h42, 1'b1);
    idle(5);
    lit("B_data_rx", data_rx, 8'h42);
    lit("B_command", command, 4);
    lit("B_dv_count", n_dv - b_dv, 1);

    // Randomized frames, gaps and glitches
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        serial_in = 1'b0;
        idle($urandom_range(1, 3));
        serial_in = 1'b1;
        idle(10);
      end
      if ($urandom_range(0, 1) == 1) b = all_chars[$urandom_range(0, 7)];
      else b = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 6) != 0);
      send_frame(b, ok);
      if (ok) idle($urandom_range(0, 12));
      else idle($urandom_range(8, 16));
    end

    idle(10);
    lit("all_frames_seen", rd_idx, exp_byte.size());
    idle(3);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
